// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmitter and the receiver.
// Holds the transmitter state encoding, the line levels and the baud divisor helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Line levels of an asynchronous serial frame
  localparam logic IDLE_LEVEL = 1'b1;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;

  // Clock cycles per bit period, truncated (5208 for 50 MHz / 9600 baud)
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer shared by the UART transmitter and receiver.
// Counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle of each bit.
// CLEAR_VAL lets the receiver preload a half-bit offset so its bit_end lands
// mid-bit; the transmitter uses 0.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int CLEAR_VAL    = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic bit_end
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CLEAR_CNT = CNT_W'(CLEAR_VAL);

  logic [CNT_W-1:0] cnt;

  // Free count within a bit; restarts at zero after the terminal count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= CLEAR_CNT;
    end else if (enable) begin
      if (cnt == LAST_CNT) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign bit_end = enable && !clear && (cnt == LAST_CNT);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one byte per valid/ready handshake, LSB first, idle-high line.
// Default framing is 8N1. Defining UART_TX_PARITY_EN inserts an even-parity bit
// between the last data bit and the stop bit.
// The serial output and both handshake outputs are registered.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk_50MHz,
  input  logic                 SW0,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_done,
  output logic                 UART2_TX
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int BIT_W        = $clog2(DATA_BITS + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  tx_state_t            state;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 bit_end;
`ifdef UART_TX_PARITY_EN
  logic                 parity_bit;
`endif

  // Bit timer runs in every frame state and is held at zero while idle
  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CLEAR_VAL   (0)
  ) u_baud_cnt (
    .clk    (clk_50MHz),
    .rst    (SW0),
    .clear  (state == IDLE),
    .enable (state != IDLE),
    .bit_end(bit_end)
  );

  // Frame sequencer; line and handshake outputs are updated on the same edge as the state
  always_ff @(posedge clk_50MHz or posedge SW0) begin
    if (SW0) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      UART2_TX  <= IDLE_LEVEL;
      tx_ready  <= 1'b1;
      tx_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            // The byte is captured here; later changes on tx_data cannot reach the line
            shift_reg <= tx_data;
            bit_cnt   <= '0;
            state     <= START;
            UART2_TX  <= START_BIT;
            tx_ready  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^tx_data;
`endif
          end else begin
            UART2_TX <= IDLE_LEVEL;
            tx_ready <= 1'b1;
          end
        end

        START: begin
          if (bit_end) begin
            state    <= DATA;
            UART2_TX <= shift_reg[0];
          end
        end

        DATA: begin
          if (bit_end) begin
            if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              state    <= PARITY;
              UART2_TX <= parity_bit;
`else
              state    <= STOP;
              UART2_TX <= STOP_BIT;
`endif
            end else begin
              // Next bit is shift_reg[1], which becomes shift_reg[0] after the shift
              bit_cnt   <= bit_cnt + 1'b1;
              shift_reg <= shift_reg >> 1;
              UART2_TX  <= shift_reg[1];
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state    <= STOP;
            UART2_TX <= STOP_BIT;
          end
        end
`endif

        STOP: begin
          if (bit_end) begin
            state    <= IDLE;
            UART2_TX <= IDLE_LEVEL;
            tx_ready <= 1'b1;
            tx_done  <= 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          UART2_TX <= IDLE_LEVEL;
          tx_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter; companion to the existing `UART` receiver block (`UART2_RX` → `data_out`).
- Serialises one byte per handshake onto `UART2_TX`: 8N1 format, LSB first, idle-high line.
- Sits between the system byte source and the board UART2 TX pin.
- Runs on the 50 MHz board clock with `SW0` as the system reset.

Parameters:
- CLK_FREQ, 50000000, input clock frequency in Hz.
- BAUD, 9600, line rate in bit/s. CLKS_PER_BIT = CLK_FREQ/BAUD with integer truncation; 5208 at defaults.
- DATA_BITS, 8, data bits per frame; legal range 5..8.

Ports:
- clk_50MHz  input  1  system clock; all logic on rising edge.
- SW0  input  1  reset, asynchronous, active-high.
- tx_data  input  DATA_BITS  byte to send; sampled only on the accept cycle.
- tx_valid  input  1  source requests a send.
- tx_ready  output  1  block can accept; high only in IDLE.
- tx_done  output  1  one-cycle pulse when a frame's stop bit completes.
- UART2_TX  output  1  serial line, registered output.

Behaviour:
- Reset (async, SW0=1):
  - UART2_TX=1, tx_ready=1, tx_done=0.
  - State=IDLE; bit counter=0; baud counter=0; shift register=0.
  - Reset asserted mid-frame aborts the frame and forces the line high immediately.
- States: IDLE, START, DATA, (PARITY), STOP.
- IDLE:
  - UART2_TX=1, tx_ready=1.
  - Accept when tx_valid && tx_ready at a rising edge. On that edge: latch tx_data into the shift register, go to START, drive UART2_TX=0, set tx_ready=0.
- Bit timing:
  - The baud counter counts 0..CLKS_PER_BIT-1 in each bit state.
  - The transition happens on the edge where the counter equals CLKS_PER_BIT-1, so each bit is held exactly CLKS_PER_BIT cycles.
- START: after CLKS_PER_BIT cycles, go to DATA and drive bit 0.
- DATA:
  - Drive shift_reg[0]; shift right at each bit boundary.
  - After DATA_BITS bits, go to STOP (or PARITY when enabled).
- STOP:
  - UART2_TX=1 for CLKS_PER_BIT cycles.
  - Then go to IDLE and pulse tx_done=1 for exactly that one cycle; tx_ready rises on the same edge.
- Timing:
  - Frame length from accept edge to IDLE = (2+DATA_BITS)*CLKS_PER_BIT cycles; 52080 at defaults.
  - Back-to-back: a tx_valid held high is accepted in the first IDLE cycle. Minimum line-high gap between frames = CLKS_PER_BIT+1 cycles.
- Ignored inputs:
  - tx_valid and tx_data are ignored while tx_ready=0; no queuing.
  - Data changes after acceptance do not affect the frame.
- Unused high data bits: none; width is fixed by DATA_BITS.
- Counter widths: $clog2(CLKS_PER_BIT) for the baud counter, $clog2(DATA_BITS+1) for the bit counter. No wrap beyond the terminal count.

Optional Feature:
- UART_TX_PARITY_EN
  - Defined: a PARITY state follows DATA and drives the even-parity bit (XOR of latched data bits) for CLKS_PER_BIT cycles before STOP. Frame = (3+DATA_BITS)*CLKS_PER_BIT cycles.
  - Undefined: no PARITY state; 8N1 framing exactly as described above.

Decomposition:
- Package uart_pkg contains:
  - typedef enum tx_state_t {IDLE, START, DATA, PARITY, STOP}
  - localparam function clks_per_bit(clk_freq, baud), shared with the receiver.
  - Constants for idle level (1), start bit (0) and stop bit (1).
- One natural sub-module, uart_baud_cnt:
  - Inputs: clear, enable. Output: bit_end pulse at CLKS_PER_BIT-1.
  - Reusable by the receiver, which instantiates it with a half-bit offset.

Test Plan:
- Reset then send 0x4A ('J') → UART2_TX reads 0,0,1,0,1,0,0,1,0,1, each held 5208 cycles. tx_ready is low for 52080 cycles; tx_done pulses once.
- tx_valid held high with 0x55 then 0xAA → two frames; idle-high gap of 5209 cycles between them; line bits match LSB-first order.
- Pulse tx_valid with 0x13 while busy during a 0xFF frame → 0x13 is never transmitted; the 0xFF frame is unchanged.
- Assert SW0 at cycle 20000 of a 0x00 frame → UART2_TX=1 immediately and tx_ready=1. After release, a new 0x3C frame transmits correctly.
- Loopback UART2_TX into the existing `UART` receiver, send 0x4A → receiver data_out=0x4A after the stop bit.
- With UART_TX_PARITY_EN defined, send 0x4A → parity bit=1 held 5208 cycles before the stop bit; frame is 57288 cycles.
